bt_frame_decoder: RTL and testbench

- Sits between the Bluetooth UART byte receiver and sum_xy.
- Assembles received bytes into fixed 6-byte joystick frames: HEADER, X, Y, BTN, CHK, TAIL.
- Checks each frame for errors.
- Presents the last good x, y and btn values with a one-cycle valid strobe, the same interface sum_xy already consumes.
- Drops malformed frames, counts them, and resynchronises on the next header.

---
 rtl/bt_frame_decoder.sv | 128 ++++++++++++
 tb/tb_bt_frame_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_frame_decoder.sv
// bt_frame_decoder: assembles 6-byte joystick frames (HEADER, X, Y, BTN, CHK, TAIL)
// from the UART byte stream. Good frames update x/y/btn with a one-cycle valid
// strobe. Malformed or timed-out frames are dropped, counted and flagged.
module bt_frame_decoder #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [7:0]  TAIL        = 8'h5A,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [7:0]       x,
  output logic [7:0]       y,
  output logic [7:0]       btn,
  output logic             valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_X,
    GET_Y,
    GET_BTN,
    GET_CHK,
    GET_TAIL
  } state_t;

  state_t        r_state;
  logic [7:0]    r_sx;
  logic [7:0]    r_sy;
  logic [7:0]    r_sbtn;
  logic [7:0]    r_acc;
  logic [TW-1:0] r_tcnt;

  logic          w_timeout;
  logic          w_err;

  // Error conditions: bad checksum, bad tail, or inter-byte timeout (a byte wins over expiry)
  always_comb begin
    w_timeout = (r_state != IDLE) && !rx_done && (r_tcnt == TW'(TIMEOUT_CYC - 1));
    w_err     = w_timeout;
    if (rx_done) begin
      if (r_state == GET_CHK && rx_data != r_acc) w_err = 1'b1;
      if (r_state == GET_TAIL && rx_data != TAIL) w_err = 1'b1;
    end
  end

  // Frame FSM with registered outputs, timeout counter and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sx      <= '0;
      r_sy      <= '0;
      r_sbtn    <= '0;
      r_acc     <= '0;
      r_tcnt    <= '0;
      x         <= '0;
      y         <= '0;
      btn       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (r_state == IDLE || rx_done || w_timeout) r_tcnt <= '0;
      else                                          r_tcnt <= r_tcnt + TW'(1);

      if (rx_done) begin
        case (r_state)
          IDLE: begin
            if (rx_data == HEADER) r_state <= GET_X;
          end
          GET_X: begin
            r_sx    <= rx_data;
            r_acc   <= r_acc ^ rx_data;
            r_state <= GET_Y;
          end
          GET_Y: begin
            r_sy    <= rx_data;
            r_acc   <= r_acc ^ rx_data;
            r_state <= GET_BTN;
          end
          GET_BTN: begin
            r_sbtn  <= rx_data;
            r_acc   <= r_acc ^ rx_data;
            r_state <= GET_CHK;
          end
          GET_CHK: begin
            r_state <= (rx_data == r_acc) ? GET_TAIL : IDLE;
          end
          GET_TAIL: begin
            r_acc <= '0;
            if (rx_data == TAIL) begin
              x       <= r_sx;
              y       <= r_sy;
              btn     <= r_sbtn;
              valid   <= 1'b1;
              r_state <= IDLE;
            end else if (rx_data == HEADER) begin
              // mismatched tail that is a header starts the next frame directly
              r_state <= GET_X;
            end else begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= IDLE;
      end

      // placed after the case so the accumulator clear overrides any XOR update
      if (w_err) begin
        frame_err <= 1'b1;
        r_acc     <= '0;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bt_frame_decoder.sv
// Scoreboard bench for bt_frame_decoder: a queue-based frame model predicts every
// valid / frame_err event (cycle, outputs, error count); a monitor pops and compares.
module tb_bt_frame_decoder;

  localparam int unsigned TO  = 50;
  localparam int unsigned CW  = 2;
  localparam logic [7:0]  HDR = 8'hA5;
  localparam logic [7:0]  TL  = 8'h5A;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [7:0]    x, y, btn;
  logic          valid, frame_err;
  logic [CW-1:0] err_count;

  bt_frame_decoder #(
    .HEADER     (HDR),
    .TAIL       (TL),
    .TIMEOUT_CYC(TO),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .x        (x),
    .y        (y),
    .btn      (btn),
    .valid    (valid),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int unsigned cyc;
    logic [7:0]  x, y, b;
    int          ec;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // reference model: bytes of the frame collected so far, idle run, visible outputs
  logic [7:0] fq[$];
  int         idle_run = 0;
  logic [7:0] mx = 0, my = 0, mb = 0;
  int         mec = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input bit e, input int unsigned c);
    ev_t ev;
    ev.is_err = e; ev.cyc = c; ev.x = mx; ev.y = my; ev.b = mb; ev.ec = mec;
    sb.push_back(ev);
  endfunction

  function automatic void model_err(input int unsigned c);
    if (mec < (1 << CW) - 1) mec++;
    push_ev(1'b1, c);
  endfunction

  function automatic void model_step(input bit done, input logic [7:0] d, input int unsigned c);
    if (!done) begin
      if (fq.size() != 0) begin
        idle_run++;
        if (idle_run == TO) begin
          fq.delete();
          idle_run = 0;
          model_err(c);
        end
      end
      return;
    end
    idle_run = 0;
    if (fq.size() == 0) begin
      if (d == HDR) fq.push_back(d);
      return;
    end
    fq.push_back(d);
    if (fq.size() == 5) begin
      if (d != (fq[1] ^ fq[2] ^ fq[3])) begin
        fq.delete();
        model_err(c);
      end
    end else if (fq.size() == 6) begin
      if (d == TL) begin
        mx = fq[1]; my = fq[2]; mb = fq[3];
        push_ev(1'b0, c);
        fq.delete();
      end else begin
        model_err(c);
        fq.delete();
        if (d == HDR) fq.push_back(d);
      end
    end
  endfunction

  // one clock of stimulus, driven just after the falling edge
  task automatic tick(input bit done, input logic [7:0] d);
    @(negedge clk);
    #1;
    rx_done = done;
    rx_data = d;
    model_step(done, d, cyc + 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) tick(1'b0, 8'h00);
    tick(1'b1, d);
  endtask

  task automatic send6(input logic [7:0] b0, b1, b2, b3, b4, b5, input int gap);
    send_byte(b0, gap); send_byte(b1, gap); send_byte(b2, gap);
    send_byte(b3, gap); send_byte(b4, gap); send_byte(b5, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    reset   = 1'b1;
    rx_done = 1'b0;
    @(negedge clk);
    chk({tag, "_x"},         x,         0);
    chk({tag, "_y"},         y,         0);
    chk({tag, "_btn"},       btn,       0);
    chk({tag, "_valid"},     valid,     0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_pending"},   sb.size(), 0);
    #1;
    reset = 1'b0;
    sb.delete();
    fq.delete();
    idle_run = 0;
    mx = 0; my = 0; mb = 0; mec = 0;
  endtask

  // monitor: every event the DUT raises must match the oldest prediction
  ev_t m_e;
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        m_e = sb.pop_front();
        $display("FAIL missed_event actual=none expected=%s@%0d", m_e.is_err ? "err" : "valid", m_e.cyc);
      end
      if (valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL valid_and_err actual=both_high expected=exclusive cyc=%0d", cyc);
      end
      if (valid || frame_err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=valid%0b_err%0b expected=none cyc=%0d", valid, frame_err, cyc);
        end else begin
          m_e = sb.pop_front();
          chk("event_cycle", int'(cyc), int'(m_e.cyc));
          chk("event_kind",  frame_err, m_e.is_err);
          chk("event_x",     x,         m_e.x);
          chk("event_y",     y,         m_e.y);
          chk("event_btn",   btn,       m_e.b);
          chk("event_cnt",   err_count, m_e.ec);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b[6];
    logic [7:0] t;
    int         g, n, r;

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_btn", btn, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_count", err_count, 0);
    #1;
    reset = 1'b0;

    // good frame with slow byte spacing
    send6(HDR, 8'h10, 8'h20, 8'h03, 8'h33, TL, 10);
    idle(3);
    chk("good_x", x, 8'h10);
    chk("good_y", y, 8'h20);
    chk("good_btn", btn, 8'h03);
    chk("good_cnt", err_count, 0);

    // bad checksum; trailing tail is discarded quietly in IDLE
    send6(HDR, 8'h10, 8'h20, 8'h03, 8'h34, TL, 2);
    idle(3);
    chk("badchk_cnt", err_count, 1);
    chk("badchk_x_held", x, 8'h10);

    // header in tail position resynchronises
    send6(HDR, 8'h01, 8'h02, 8'h04, 8'h07, HDR, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h00, 1);
    send_byte(8'h33, 1); send_byte(TL, 1);
    idle(3);
    chk("resync_x", x, 8'h11);
    chk("resync_y", y, 8'h22);
    chk("resync_btn", btn, 8'h00);
    chk("resync_cnt", err_count, 2);

    // timeout, then recovery; then a gap one short of expiry must survive
    do_reset("rst_a");
    send_byte(HDR, 0);
    send_byte(8'h10, 0);
    idle(TO + 10);
    chk("timeout_cnt", err_count, 1);
    send6(HDR, 8'h10, 8'h20, 8'h03, 8'h33, TL, 0);
    send_byte(HDR, 0);
    send_byte(8'h44, TO - 1);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    send_byte(8'h44 ^ 8'h55 ^ 8'h66, 0); send_byte(TL, 0);
    idle(3);
    chk("edge_gap_x", x, 8'h44);
    chk("edge_gap_cnt", err_count, 1);

    // garbage in IDLE, then two back-to-back frames
    do_reset("rst_b");
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(TL, 0);
    send6(HDR, 8'h01, 8'h02, 8'h03, 8'h00, TL, 0);
    send6(HDR, 8'h0A, 8'h0B, 8'h0C, 8'h0D, TL, 0);
    idle(3);
    chk("b2b_x", x, 8'h0A);
    chk("b2b_y", y, 8'h0B);
    chk("b2b_btn", btn, 8'h0C);
    chk("b2b_cnt", err_count, 0);

    // saturation of the 2-bit counter, then reset mid-frame
    do_reset("rst_c");
    repeat (5) send6(HDR, 8'h10, 8'h20, 8'h03, 8'h99, TL, 0);
    idle(3);
    chk("sat_cnt", err_count, 3);
    send_byte(HDR, 0);
    send_byte(8'h10, 0);
    do_reset("rst_mid");

    // randomized frames with corruption, garbage, truncation and long gaps
    for (int f = 0; f < 300; f++) begin
      b[0] = HDR;
      b[1] = 8'($urandom);
      b[2] = 8'($urandom);
      b[3] = 8'($urandom);
      b[4] = b[1] ^ b[2] ^ b[3];
      b[5] = TL;
      r = $urandom_range(0, 9);
      t = 8'($urandom_range(1, 255));
      if (r == 0) b[4] = b[4] ^ t;
      if (r == 1) b[5] = (t == TL) ? HDR : t;
      if (r == 2) b[0] = 8'($urandom);
      n = (r == 3) ? $urandom_range(1, 5) : 6;
      for (int i = 0; i < n; i++) begin
        g = $urandom_range(0, 3);
        if ($urandom_range(0, 49) == 0) g = TO - 1;
        if ($urandom_range(0, 79) == 0) g = TO + $urandom_range(0, 5);
        send_byte(b[i], g);
      end
    end

    idle(TO + 20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
